// File: rtl/hrm_boot_pkg.sv
// hrm_boot_pkg
//   Shared definitions for the HRM IRAM boot loader: FSM state encoding,
//   default frame header byte, maximum frame length and the small helpers
//   used by the checksum and word-count logic.
package hrm_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CSUM  = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERR   = 3'd6
  } boot_state_t;

  localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
  localparam int unsigned MAX_WORDS   = 128;

  // Running frame checksum: plain XOR over every data byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // A count byte of zero encodes a full 128-word image.
  function automatic logic [7:0] decode_count(input logic [7:0] n);
    return (n == 8'd0) ? 8'(MAX_WORDS) : n;
  endfunction

endpackage

// File: rtl/boot_timer.sv
// boot_timer
//   Idle-cycle watchdog for an in-progress boot frame.
//   Ports:
//     CLK     - system clock
//     RESET   - asynchronous active-high reset
//     CLEAR   - restart the count (a byte was accepted this cycle)
//     ENABLE  - count only while high; held at zero otherwise
//     EXPIRED - high in the cycle whose rising edge brings the count to TIMEOUT
module boot_timer #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLEAR,
  input  logic ENABLE,
  output logic EXPIRED
);

  localparam int unsigned      CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Flag is combinational so the FSM leaves on the same edge the count hits TIMEOUT.
  assign EXPIRED = ENABLE && !CLEAR && (cnt_r == LAST);

  // Idle counter: cleared on accepted bytes or when disabled, saturates at TIMEOUT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (CLEAR || !ENABLE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != LIMIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/iram_boot_ctrl.sv
// iram_boot_ctrl
//   Loads the HRM CPU's 128x16 instruction RAM from a framed byte stream
//   (HDR, N, 2N data bytes high-first, XOR checksum) and holds the CPU in
//   reset until a frame completes with a good checksum.
//   Ports:
//     CLK, RESET             - clock, asynchronous active-high reset
//     RX_DATA/VALID/READY    - host byte link (byte taken on VALID && READY)
//     BOOT_REQ               - reload request, honoured in RUN or ERR only
//     IRAM_WE/WADDR/WDATA    - registered IRAM write port, one pulse per word
//     CPU_RESET              - CPU held in reset while high
//     LOAD_DONE / LOAD_ERR   - frame loaded OK / frame rejected
//     WORDS                  - words written in the current or last frame
module iram_boot_ctrl
  import hrm_boot_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  HDR     = HDR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  input  logic        BOOT_REQ,
  output logic        IRAM_WE,
  output logic [6:0]  IRAM_WADDR,
  output logic [15:0] IRAM_WDATA,
  output logic        CPU_RESET,
  output logic        LOAD_DONE,
  output logic        LOAD_ERR,
  output logic [7:0]  WORDS
);

  boot_state_t state_r;
  boot_state_t state_s;

  logic        frame_s;
  logic        rx_ready_s;
  logic        accept_s;
  logic        timeout_s;

  logic [7:0]  n_r;
  logic [7:0]  hi_r;
  logic [7:0]  acc_r;
  logic [7:0]  words_r;
  logic [6:0]  addr_r;
  logic [6:0]  waddr_r;
  logic [15:0] wdata_r;
  logic        we_r;
  logic        cpu_reset_r;
  logic        load_done_r;
  logic        load_err_r;

  // Ready depends on state only, so BOOT_REQ in RUN/ERR can never race a byte.
  assign frame_s    = (state_r == ST_COUNT) || (state_r == ST_HI) ||
                      (state_r == ST_LO)    || (state_r == ST_CSUM);
  assign rx_ready_s = frame_s || (state_r == ST_IDLE);
  assign accept_s   = RX_VALID && rx_ready_s;

  boot_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .CLEAR   (accept_s),
    .ENABLE  (frame_s),
    .EXPIRED (timeout_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode; a frame-state timeout overrides byte handling.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (RX_DATA == HDR)) state_s = ST_COUNT;
        else                              state_s = ST_IDLE;
      end
      ST_COUNT: begin
        if (timeout_s)     state_s = ST_ERR;
        else if (accept_s) state_s = ST_HI;
        else               state_s = ST_COUNT;
      end
      ST_HI: begin
        if (timeout_s)     state_s = ST_ERR;
        else if (accept_s) state_s = ST_LO;
        else               state_s = ST_HI;
      end
      ST_LO: begin
        if (timeout_s) begin
          state_s = ST_ERR;
        end else if (accept_s) begin
          // words_r counts words already written, so +1 is the word being finished.
          if ((words_r + 8'd1) == n_r) state_s = ST_CSUM;
          else                         state_s = ST_HI;
        end else begin
          state_s = ST_LO;
        end
      end
      ST_CSUM: begin
        if (timeout_s) begin
          state_s = ST_ERR;
        end else if (accept_s) begin
          if (RX_DATA == acc_r) state_s = ST_RUN;
          else                  state_s = ST_ERR;
        end else begin
          state_s = ST_CSUM;
        end
      end
      ST_RUN: begin
        if (BOOT_REQ) state_s = ST_IDLE;
        else          state_s = ST_RUN;
      end
      ST_ERR: begin
        if (BOOT_REQ) state_s = ST_IDLE;
        else          state_s = ST_ERR;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Frame datapath, IRAM write port and status outputs (status follows next state).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      n_r         <= 8'd0;
      hi_r        <= 8'd0;
      acc_r       <= 8'd0;
      words_r     <= 8'd0;
      addr_r      <= 7'd0;
      waddr_r     <= 7'd0;
      wdata_r     <= 16'd0;
      we_r        <= 1'b0;
      cpu_reset_r <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      we_r        <= 1'b0;
      cpu_reset_r <= (state_s != ST_RUN);
      load_done_r <= (state_s == ST_RUN);
      load_err_r  <= (state_s == ST_ERR);
      if (accept_s) begin
        case (state_r)
          ST_COUNT: begin
            n_r     <= decode_count(RX_DATA);
            acc_r   <= 8'd0;
            addr_r  <= 7'd0;
            words_r <= 8'd0;
          end
          ST_HI: begin
            hi_r  <= RX_DATA;
            acc_r <= csum_step(acc_r, RX_DATA);
          end
          ST_LO: begin
            acc_r   <= csum_step(acc_r, RX_DATA);
            wdata_r <= {hi_r, RX_DATA};
            waddr_r <= addr_r;
            we_r    <= 1'b1;
            addr_r  <= addr_r + 7'd1;
            words_r <= words_r + 8'd1;
          end
          default: begin
            n_r <= n_r;
          end
        endcase
      end
    end
  end

  assign RX_READY   = rx_ready_s;
  assign IRAM_WE    = we_r;
  assign IRAM_WADDR = waddr_r;
  assign IRAM_WDATA = wdata_r;
  assign CPU_RESET  = cpu_reset_r;
  assign LOAD_DONE  = load_done_r;
  assign LOAD_ERR   = load_err_r;
  assign WORDS      = words_r;

endmodule

// File: tb/tb_iram_boot_ctrl.sv
// tb_iram_boot_ctrl
//   Directed bench for iram_boot_ctrl (TIMEOUT reduced to 16). Drives frames
//   byte by byte, records every IRAM write, and compares against hand-computed
//   expectations with immediate assertions.
module tb_iram_boot_ctrl;

  logic        CLK;
  logic        RESET;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        BOOT_REQ;
  logic        IRAM_WE;
  logic [6:0]  IRAM_WADDR;
  logic [15:0] IRAM_WDATA;
  logic        CPU_RESET;
  logic        LOAD_DONE;
  logic        LOAD_ERR;
  logic [7:0]  WORDS;

  int n_checks = 0;
  int n_fails  = 0;

  logic [6:0]  wa_q[$];
  logic [15:0] wd_q[$];

  iram_boot_ctrl #(
    .TIMEOUT (16),
    .HDR     (8'hA5)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .RX_READY   (RX_READY),
    .BOOT_REQ   (BOOT_REQ),
    .IRAM_WE    (IRAM_WE),
    .IRAM_WADDR (IRAM_WADDR),
    .IRAM_WDATA (IRAM_WDATA),
    .CPU_RESET  (CPU_RESET),
    .LOAD_DONE  (LOAD_DONE),
    .LOAD_ERR   (LOAD_ERR),
    .WORDS      (WORDS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write monitor: logs every IRAM write strobe seen just after a rising edge.
  always @(posedge CLK) begin
    #1;
    if (IRAM_WE === 1'b1) begin
      wa_q.push_back(IRAM_WADDR);
      wd_q.push_back(IRAM_WDATA);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic boot_req();
    BOOT_REQ = 1'b1;
    tick();
    BOOT_REQ = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cpu_reset"}, CPU_RESET, 1);
    chk({tag, "_we"}, IRAM_WE, 0);
    chk({tag, "_waddr"}, IRAM_WADDR, 0);
    chk({tag, "_wdata"}, IRAM_WDATA, 0);
    chk({tag, "_done"}, LOAD_DONE, 0);
    chk({tag, "_err"}, LOAD_ERR, 0);
    chk({tag, "_words"}, WORDS, 0);
    chk({tag, "_ready"}, RX_READY, 1);
  endtask

  initial begin
    int bad;
    logic [15:0] exp_w;

    RESET    = 1'b1;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    BOOT_REQ = 1'b0;
    tick();
    tick();
    chk_reset_values("rst");
    RESET = 1'b0;
    tick();

    // Good two-word frame.
    clear_log();
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB);
    chk("a_cpu_reset_mid", CPU_RESET, 1);
    send(8'hCD);
    chk("a_we_last", IRAM_WE, 1);
    chk("a_waddr_last", IRAM_WADDR, 1);
    chk("a_wdata_last", IRAM_WDATA, 16'hABCD);
    chk("a_cpu_reset_before_csum", CPU_RESET, 1);
    send(8'h40);
    chk("a_we_after", IRAM_WE, 0);
    chk("a_cpu_reset", CPU_RESET, 0);
    chk("a_done", LOAD_DONE, 1);
    chk("a_words", WORDS, 2);
    chk("a_ready", RX_READY, 0);
    tick();
    chk("a_nwrites", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk("a_w0_addr", wa_q[0], 0);
      chk("a_w0_data", wd_q[0], 16'h1234);
      chk("a_w1_addr", wa_q[1], 1);
      chk("a_w1_data", wd_q[1], 16'hABCD);
    end
    boot_req();
    chk("a_req_cpu_reset", CPU_RESET, 1);
    chk("a_req_ready", RX_READY, 1);
    chk("a_req_done", LOAD_DONE, 0);

    // Same frame with a bad checksum.
    clear_log();
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h41);
    chk("b_err", LOAD_ERR, 1);
    chk("b_done", LOAD_DONE, 0);
    chk("b_cpu_reset", CPU_RESET, 1);
    chk("b_words", WORDS, 2);
    chk("b_nwrites", wa_q.size(), 2);
    RX_DATA  = 8'hA5;
    RX_VALID = 1'b1;
    chk("b_ready_in_err", RX_READY, 0);
    tick();
    RX_VALID = 1'b0;
    chk("b_still_err", LOAD_ERR, 1);
    boot_req();
    chk("b_req_ready", RX_READY, 1);
    chk("b_req_err", LOAD_ERR, 0);
    chk("b_req_cpu_reset", CPU_RESET, 1);

    // Leading garbage before the header.
    clear_log();
    send(8'h00); send(8'hFF);
    send(8'hA5); send(8'h01); send(8'hF0); send(8'h01); send(8'hF1);
    chk("c_done", LOAD_DONE, 1);
    chk("c_cpu_reset", CPU_RESET, 0);
    chk("c_words", WORDS, 1);
    chk("c_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      chk("c_w0_addr", wa_q[0], 0);
      chk("c_w0_data", wd_q[0], 16'hF001);
    end
    boot_req();

    // Full 128-word frame (count byte 0); XOR of 0..255 is 0.
    clear_log();
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    send(8'h00);
    chk("d_done", LOAD_DONE, 1);
    chk("d_words", WORDS, 8'h80);
    chk("d_nwrites", wa_q.size(), 128);
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      exp_w = {8'(2 * k), 8'(2 * k + 1)};
      if (k >= wa_q.size()) bad++;
      else if ((wa_q[k] !== 7'(k)) || (wd_q[k] !== exp_w)) bad++;
    end
    chk("d_word_map", bad, 0);
    boot_req();

    // Idle timeout inside a frame.
    clear_log();
    send(8'hA5); send(8'h02); send(8'h12);
    for (int i = 0; i < 15; i++) tick();
    chk("e_no_err_at_15", LOAD_ERR, 0);
    chk("e_ready_at_15", RX_READY, 1);
    tick();
    chk("e_err_at_16", LOAD_ERR, 1);
    chk("e_ready_err", RX_READY, 0);
    chk("e_cpu_reset", CPU_RESET, 1);
    chk("e_nwrites", wa_q.size(), 0);
    boot_req();
    chk("e_req_ready", RX_READY, 1);

    // Reset in the middle of a frame.
    clear_log();
    send(8'hA5); send(8'h01); send(8'h12);
    RESET = 1'b1;
    #1;
    chk_reset_values("f_async");
    tick();
    chk_reset_values("f_hold");
    RESET = 1'b0;
    tick();
    chk("f_nwrites", wa_q.size(), 0);
    send(8'hA5); send(8'h01); send(8'hF0); send(8'h01); send(8'hF1);
    chk("f_done", LOAD_DONE, 1);
    chk("f_words", WORDS, 1);
    chk("f_nwrites_after", wa_q.size(), 1);

    // BOOT_REQ and a byte in the same cycle while in RUN.
    BOOT_REQ = 1'b1;
    RX_DATA  = 8'hA5;
    RX_VALID = 1'b1;
    chk("g_ready_run", RX_READY, 0);
    tick();
    BOOT_REQ = 1'b0;
    RX_VALID = 1'b0;
    chk("g_ready_idle", RX_READY, 1);
    chk("g_cpu_reset", CPU_RESET, 1);
    chk("g_done", LOAD_DONE, 0);
    clear_log();
    send(8'hA5); send(8'h01); send(8'h34); send(8'h12); send(8'h26);
    chk("g_reload_done", LOAD_DONE, 1);
    chk("g_reload_words", WORDS, 1);
    chk("g_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      chk("g_w0_addr", wa_q[0], 0);
      chk("g_w0_data", wd_q[0], 16'h3412);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
